// File: rtl/sram_axi_rr.sv
// AXI4-Lite slave to single-port SRAM bridge with read/write arbitration and
// credit-guarded read-return FIFO so returning read data can never overflow it.
module sram_axi_rr #(
    parameter int ADDR_WIDTH    = 18,
    parameter int DATA_WIDTH    = 16,
    parameter int RD_FIFO_DEPTH = 4,
    parameter int ARB_MODE      = 0
) (
    input  logic                    a_clk,
    input  logic                    a_rst,
    input  logic                    aw_valid,
    output logic                    aw_ready,
    input  logic [ADDR_WIDTH-1:0]   aw_addr,
    input  logic                    w_valid,
    output logic                    w_ready,
    input  logic [DATA_WIDTH-1:0]   w_data,
    input  logic [DATA_WIDTH/8-1:0] w_strb,
    output logic                    b_valid,
    input  logic                    b_ready,
    output logic [1:0]              b_resp,
    input  logic                    ar_valid,
    output logic                    ar_ready,
    input  logic [ADDR_WIDTH-1:0]   ar_addr,
    output logic                    r_valid,
    input  logic                    r_ready,
    output logic [DATA_WIDTH-1:0]   r_data,
    output logic [1:0]              r_resp,
    output logic                    sram_req,
    input  logic                    sram_ready,
    output logic                    sram_rd,
    output logic [ADDR_WIDTH-1:0]   sram_addr,
    output logic [DATA_WIDTH/8-1:0] sram_be,
    output logic [DATA_WIDTH-1:0]   sram_wr_data,
    input  logic                    sram_rd_data_vld,
    input  logic [DATA_WIDTH-1:0]   sram_rd_data,
    output logic                    rd_error
);
    localparam int BW = DATA_WIDTH / 8;
    localparam int PW = $clog2(RD_FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                state_q, state_d;
    logic                  last_rd_q, last_rd_d;
    logic                  b_pending_q, b_pending_d;
    logic                  b_valid_q, b_valid_d;
    logic                  sram_req_q, sram_req_d;
    logic                  sram_rd_q, sram_rd_d;
    logic [ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
    logic [BW-1:0]         sram_be_q, sram_be_d;
    logic [DATA_WIDTH-1:0] sram_wr_data_q, sram_wr_data_d;
    logic [CW-1:0]         credits_q, credits_d;
    logic [CW-1:0]         rd_inflight_q, rd_inflight_d;
    logic [CW-1:0]         count_q, count_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] mem_q [RD_FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [RD_FIFO_DEPTH];
    logic                  rd_error_q, rd_error_d;

    logic b_hs, r_hs, wr_ok, rd_ok, grant_wr, grant_rd, sram_done, push;

    always_comb begin
        b_hs      = b_valid_q & b_ready;
        r_hs      = (count_q != '0) & r_ready;
        // A write may be granted in the very cycle its predecessor's B response retires.
        wr_ok     = aw_valid & w_valid & ~(b_pending_q & ~b_hs);
        rd_ok     = ar_valid & (credits_q != '0);
        grant_wr  = 1'b0;
        grant_rd  = 1'b0;
        if (state_q == IDLE) begin
            if (rd_ok && wr_ok) begin
                if (ARB_MODE == 1 || !last_rd_q) grant_rd = 1'b1;
                else                             grant_wr = 1'b1;
            end else begin
                grant_rd = rd_ok;
                grant_wr = wr_ok;
            end
        end
        sram_done = (state_q == BUSY) & sram_ready;
        push      = sram_rd_data_vld & (rd_inflight_q != '0);
    end

    always_comb begin
        state_d        = state_q;
        last_rd_d      = last_rd_q;
        sram_req_d     = sram_req_q;
        sram_rd_d      = sram_rd_q;
        sram_addr_d    = sram_addr_q;
        sram_be_d      = sram_be_q;
        sram_wr_data_d = sram_wr_data_q;
        b_pending_d    = b_pending_q;
        b_valid_d      = b_valid_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        mem_d          = mem_q;

        if (grant_wr) begin
            state_d        = BUSY;
            last_rd_d      = 1'b0;
            sram_req_d     = 1'b1;
            sram_rd_d      = 1'b0;
            sram_addr_d    = aw_addr;
            sram_be_d      = w_strb;
            sram_wr_data_d = w_data;
        end else if (grant_rd) begin
            state_d     = BUSY;
            last_rd_d   = 1'b1;
            sram_req_d  = 1'b1;
            sram_rd_d   = 1'b1;
            sram_addr_d = ar_addr;
            sram_be_d   = '1;
        end else if (sram_done) begin
            state_d    = IDLE;
            sram_req_d = 1'b0;
        end

        if (b_hs)                     b_valid_d   = 1'b0;
        if (sram_done && !sram_rd_q)  b_valid_d   = 1'b1;
        if (b_hs)                     b_pending_d = 1'b0;
        if (grant_wr)                 b_pending_d = 1'b1;

        if (push) begin
            mem_d[wr_ptr_q] = sram_rd_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (r_hs) rd_ptr_d = rd_ptr_q + PW'(1);

        credits_d     = credits_q - CW'(grant_rd) + CW'(r_hs);
        rd_inflight_d = rd_inflight_q + CW'(sram_done & sram_rd_q) - CW'(push);
        count_d       = count_q + CW'(push) - CW'(r_hs);
        // Data with nothing in flight (e.g. a read abandoned by reset) is dropped and flagged.
        rd_error_d    = rd_error_q | (sram_rd_data_vld & (rd_inflight_q == '0));
    end

    always_ff @(posedge a_clk or posedge a_rst) begin
        if (a_rst) begin
            state_q        <= IDLE;
            last_rd_q      <= 1'b0;
            sram_req_q     <= 1'b0;
            sram_rd_q      <= 1'b0;
            sram_addr_q    <= '0;
            sram_be_q      <= '0;
            sram_wr_data_q <= '0;
            b_pending_q    <= 1'b0;
            b_valid_q      <= 1'b0;
            credits_q      <= CW'(RD_FIFO_DEPTH);
            rd_inflight_q  <= '0;
            count_q        <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            rd_error_q     <= 1'b0;
            for (int i = 0; i < RD_FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q        <= state_d;
            last_rd_q      <= last_rd_d;
            sram_req_q     <= sram_req_d;
            sram_rd_q      <= sram_rd_d;
            sram_addr_q    <= sram_addr_d;
            sram_be_q      <= sram_be_d;
            sram_wr_data_q <= sram_wr_data_d;
            b_pending_q    <= b_pending_d;
            b_valid_q      <= b_valid_d;
            credits_q      <= credits_d;
            rd_inflight_q  <= rd_inflight_d;
            count_q        <= count_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            rd_error_q     <= rd_error_d;
            mem_q          <= mem_d;
        end
    end

    assign aw_ready     = grant_wr;
    assign w_ready      = grant_wr;
    assign ar_ready     = grant_rd;
    assign b_valid      = b_valid_q;
    assign b_resp       = 2'b00;
    assign r_valid      = (count_q != '0);
    assign r_data       = mem_q[rd_ptr_q];
    assign r_resp       = 2'b00;
    assign sram_req     = sram_req_q;
    assign sram_rd      = sram_rd_q;
    assign sram_addr    = sram_addr_q;
    assign sram_be      = sram_be_q;
    assign sram_wr_data = sram_wr_data_q;
    assign rd_error     = rd_error_q;
endmodule
